// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
//  Module      : stack_unit
//  Description : Stack-handshake responder; owns SP and drives the data-memory
//                address/write data for two-byte {PC, flags} frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_unit #(
    parameter logic [7:0] STACK_TOP = 8'hFF,
    parameter int          DEPTH     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stack_op_ongoing,
    input  logic       push_or_pop,
    input  logic       bus_grant,
    input  logic [7:0] pc_in,
    input  logic [5:0] flags_in,
    input  logic [7:0] stack_rd_data,
    output logic [7:0] stack_addr,
    output logic [7:0] stack_wr_data,
    output logic       stack_op_end,
    output logic [7:0] pc_out,
    output logic [5:0] flags_out,
    output logic [7:0] sp_out,
    output logic       stk_ovf,
    output logic       stk_unf
);

    localparam logic       PUSH = 1'b1;
    localparam logic       POP  = 1'b0;
    // Compared in 9 bits so a parameter set near the byte boundary cannot wrap.
    localparam logic [8:0] PUSH_MIN = {1'b0, STACK_TOP} - 9'(2 * DEPTH) + 9'd2;
    localparam logic [8:0] POP_MAX  = {1'b0, STACK_TOP} - 9'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_SECOND = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] sp_q, sp_d;
    logic       dir_q, dir_d;
    logic       bad_q, bad_d;
    logic [7:0] pc_q, pc_d;
    logic [5:0] flags_q, flags_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;

    logic       w_dir;
    logic       w_legal;
    logic       w_first;

    assign w_dir   = (state_q == S_IDLE) ? push_or_pop : dir_q;
    assign w_legal = (w_dir == PUSH) ? ({1'b0, sp_q} >= PUSH_MIN)
                                     : ({1'b0, sp_q} <= POP_MAX);
    assign w_first = (state_q != S_SECOND);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sp_q    <= STACK_TOP;
            dir_q   <= POP;
            bad_q   <= 1'b0;
            pc_q    <= 8'h00;
            flags_q <= 6'h00;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            dir_q   <= dir_d;
            bad_q   <= bad_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sp_d          = sp_q;
        dir_d         = dir_q;
        bad_d         = bad_q;
        pc_d          = pc_q;
        flags_d       = flags_q;
        ovf_d         = ovf_q;
        unf_d         = unf_q;
        stack_op_end  = 1'b0;
        stack_addr    = sp_q;
        stack_wr_data = 8'h00;

        if (stack_op_ongoing) begin
            if (w_dir == PUSH) begin
                stack_addr    = w_first ? sp_q : (sp_q - 8'd1);
                stack_wr_data = w_first ? pc_in : {2'b00, flags_in};
            end else begin
                stack_addr    = w_first ? (sp_q + 8'd1) : (sp_q + 8'd2);
            end

            unique case (state_q)
                S_IDLE: begin
                    // The IDLE cycle that sees ongoing is already the first access.
                    dir_d = push_or_pop;
                    bad_d = !w_legal;
                    if (!w_legal) begin
                        if (push_or_pop == PUSH) ovf_d = 1'b1;
                        else                     unf_d = 1'b1;
                    end
                    if (bus_grant) begin
                        state_d = S_SECOND;
                        if (push_or_pop == POP) flags_d = stack_rd_data[5:0];
                    end else begin
                        state_d = S_FIRST;
                    end
                end
                S_FIRST: begin
                    if (bus_grant) begin
                        state_d = S_SECOND;
                        if (dir_q == POP) flags_d = stack_rd_data[5:0];
                    end
                end
                S_SECOND: begin
                    if (bus_grant) begin
                        stack_op_end = 1'b1;
                        state_d      = S_IDLE;
                        if (dir_q == POP) pc_d = stack_rd_data;
                        if (!bad_q) sp_d = (dir_q == PUSH) ? (sp_q - 8'd2) : (sp_q + 8'd2);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            state_d = S_IDLE;
        end
    end

    assign pc_out    = pc_q;
    assign flags_out = flags_q;
    assign sp_out    = sp_q;
    assign stk_ovf   = ovf_q;
    assign stk_unf   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_unit
//  Description : Directed scoreboard bench for stack_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_unit;

    logic       clk;
    logic       rst;
    logic       stack_op_ongoing;
    logic       push_or_pop;
    logic       bus_grant;
    logic [7:0] pc_in;
    logic [5:0] flags_in;
    logic [7:0] stack_rd_data;
    logic [7:0] stack_addr;
    logic [7:0] stack_wr_data;
    logic       stack_op_end;
    logic [7:0] pc_out;
    logic [5:0] flags_out;
    logic [7:0] sp_out;
    logic       stk_ovf;
    logic       stk_unf;

    stack_unit #(.STACK_TOP(8'hFF), .DEPTH(16)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .stack_op_ongoing (stack_op_ongoing),
        .push_or_pop      (push_or_pop),
        .bus_grant        (bus_grant),
        .pc_in            (pc_in),
        .flags_in         (flags_in),
        .stack_rd_data    (stack_rd_data),
        .stack_addr       (stack_addr),
        .stack_wr_data    (stack_wr_data),
        .stack_op_end     (stack_op_end),
        .pc_out           (pc_out),
        .flags_out        (flags_out),
        .sp_out           (sp_out),
        .stk_ovf          (stk_ovf),
        .stk_unf          (stk_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       is_wr;
        logic       last;
    } acc_t;

    acc_t       sb[$];
    logic [7:0] mem [256];
    logic [7:0] sp_m;
    logic [7:0] pc_m;
    logic [5:0] fl_m;
    logic       ovf_m;
    logic       unf_m;
    int         checks;
    int         failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sp_m  = 8'hFF;
        pc_m  = 8'h00;
        fl_m  = 6'h00;
        ovf_m = 1'b0;
        unf_m = 1'b0;
        sb.delete();
    endtask

    // One access: hold with grant low for 'waits' cycles, then grant.
    task automatic access(input int waits);
        acc_t e;
        e = sb[0];
        for (int i = 0; i < waits; i++) begin
            bus_grant = 1'b0;
            @(negedge clk);
            chk("wait_addr", 32'(stack_addr), 32'(e.addr));
            if (e.is_wr) chk("wait_data", 32'(stack_wr_data), 32'(e.data));
            chk("wait_end", 32'(stack_op_end), 32'd0);
            @(posedge clk); #1;
        end
        bus_grant     = 1'b1;
        stack_rd_data = mem[e.addr];
        @(negedge clk);
        e = sb.pop_front();
        chk("grant_addr", 32'(stack_addr), 32'(e.addr));
        if (e.is_wr) chk("grant_data", 32'(stack_wr_data), 32'(e.data));
        chk("grant_end", 32'(stack_op_end), 32'(e.last));
        if (e.is_wr) mem[e.addr] = e.data;
        @(posedge clk); #1;
    endtask

    task automatic post_check(input string tag);
        @(negedge clk);
        chk({tag, "_sp"},    32'(sp_out),       32'(sp_m));
        chk({tag, "_pc"},    32'(pc_out),       32'(pc_m));
        chk({tag, "_flags"}, 32'(flags_out),    32'(fl_m));
        chk({tag, "_ovf"},   32'(stk_ovf),      32'(ovf_m));
        chk({tag, "_unf"},   32'(stk_unf),      32'(unf_m));
        chk({tag, "_idle"},  32'(stack_addr),   32'(sp_m));
        chk({tag, "_noend"}, 32'(stack_op_end), 32'd0);
        @(posedge clk); #1;
    endtask

    // Full op; push_or_pop is inverted after the first access to exercise the latch.
    task automatic op(input string tag, input logic dir, input logic [7:0] pc,
                      input logic [5:0] fl, input int waits, input bit abort);
        logic [7:0] a0, a1;
        logic       legal;
        legal = dir ? (sp_m >= 8'hE1) : (sp_m <= 8'hFD);
        a0    = dir ? sp_m : (sp_m + 8'd1);
        a1    = dir ? (sp_m - 8'd1) : (sp_m + 8'd2);
        sb.push_back('{a0, pc, dir, 1'b0});
        sb.push_back('{a1, {2'b00, fl}, dir, 1'b1});
        stack_op_ongoing = 1'b1;
        push_or_pop      = dir;
        pc_in            = pc;
        flags_in         = fl;
        access(waits);
        if (!legal) begin
            if (dir) ovf_m = 1'b1;
            else     unf_m = 1'b1;
        end
        if (!dir) fl_m = mem[a0][5:0];
        push_or_pop = ~dir;
        if (abort) begin
            void'(sb.pop_front());
            stack_op_ongoing = 1'b0;
            bus_grant        = 1'b0;
            @(negedge clk);
            chk({tag, "_abort_end"}, 32'(stack_op_end), 32'd0);
            @(posedge clk); #1;
        end else begin
            access(waits);
            stack_op_ongoing = 1'b0;
            bus_grant        = 1'b0;
            if (!dir) pc_m = mem[a1];
            if (legal) sp_m = dir ? (sp_m - 8'd2) : (sp_m + 8'd2);
        end
        post_check(tag);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        model_reset();
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b0;
        stack_op_ongoing = 1'b0;
        push_or_pop      = 1'b0;
        bus_grant        = 1'b0;
        pc_in            = 8'h00;
        flags_in         = 6'h00;
        stack_rd_data    = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        model_reset();

        #12;
        chk("rst_sp",    32'(sp_out),       32'hFF);
        chk("rst_end",   32'(stack_op_end), 32'd0);
        chk("rst_pc",    32'(pc_out),       32'd0);
        chk("rst_flags", 32'(flags_out),    32'd0);
        chk("rst_ovf",   32'(stk_ovf),      32'd0);
        chk("rst_unf",   32'(stk_unf),      32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        op("push0",   1'b1, 8'h3A, 6'b101001, 0, 1'b0);
        op("pop0",    1'b0, 8'h00, 6'h00,     0, 1'b0);
        op("pushw",   1'b1, 8'h5C, 6'b010110, 3, 1'b0);
        op("popw",    1'b0, 8'h00, 6'h00,     2, 1'b0);
        op("push1",   1'b1, 8'hC3, 6'b111111, 1, 1'b0);

        // Async reset in the middle of a push (after the first grant).
        stack_op_ongoing = 1'b1;
        push_or_pop      = 1'b1;
        pc_in            = 8'h77;
        flags_in         = 6'h15;
        bus_grant        = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        chk("midrst_sp",    32'(sp_out),       32'hFF);
        chk("midrst_end",   32'(stack_op_end), 32'd0);
        chk("midrst_flags", 32'(flags_out),    32'd0);
        chk("midrst_pc",    32'(pc_out),       32'd0);
        stack_op_ongoing = 1'b0;
        bus_grant        = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("midrst_addr", 32'(stack_addr), 32'hFF);
        @(posedge clk); #1;

        op("abort_push", 1'b1, 8'h11, 6'h22, 0, 1'b1);
        op("abort_pop",  1'b0, 8'h00, 6'h00, 1, 1'b1);

        for (int i = 0; i < 16; i++)
            op("fill", 1'b1, 8'(8'h40 + i), 6'(i * 3), i % 2, 1'b0);
        chk("full_sp", 32'(sp_out), 32'hDF);
        op("ovf_push", 1'b1, 8'hEE, 6'h3F, 0, 1'b0);
        op("after_ovf_pop", 1'b0, 8'h00, 6'h00, 0, 1'b0);

        do_reset();
        op("unf_pop", 1'b0, 8'h00, 6'h00, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
